and_response_checker: RTL and testbench

- Hardware self-checking monitor for the 4-bit AND gate datapath. It is the receive end of the stimulus stream a bench or pattern source drives into the gate.
- Accepts {A, B, observed T} vectors over a valid/ready handshake and computes the expected A&B internally.
- Counts passes and fails, and captures the first mismatching vector for debug.
- Sits beside the gate under test; a run is framed by a start pulse and a last flag.

---
 rtl/and_response_checker.sv | 148 ++++++++++++++
 tb/tb_and_response_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/and_response_checker.sv
// Receive-side monitor for the AND gate datapath. It checks each observed T against A&B,
// counts passes, fails and accepted vectors per run, and captures the first mismatching vector.
module and_response_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] t,
  input  logic             last,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vec_idx,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic [WIDTH-1:0] first_fail_t
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0] ff_a_q, ff_a_d;
  logic [WIDTH-1:0] ff_b_q, ff_b_d;
  logic [WIDTH-1:0] ff_t_q, ff_t_d;

  logic             accept;
  logic [WIDTH-1:0] expected;
  logic             match;

  // Counters stick at all-ones so a long run never reports a wrapped small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign accept   = vec_valid && (state_q == S_RUN);
  assign expected = a & b;
  assign match    = (t == expected);

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    vec_idx_d  = vec_idx_q;
    ff_idx_d   = ff_idx_q;
    ff_a_d     = ff_a_q;
    ff_b_d     = ff_b_q;
    ff_t_d     = ff_t_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          error_d    = 1'b0;
          pass_cnt_d = '0;
          fail_cnt_d = '0;
          vec_idx_d  = '0;
          ff_idx_d   = '0;
          ff_a_d     = '0;
          ff_b_d     = '0;
          ff_t_d     = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          vec_idx_d = sat_inc(vec_idx_q);
          if (match) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
          end else begin
            fail_cnt_d = sat_inc(fail_cnt_q);
            error_d    = 1'b1;
            if (fail_cnt_q == '0) begin
              ff_idx_d = vec_idx_q;
              ff_a_d   = a;
              ff_b_d   = b;
              ff_t_d   = t;
            end
          end
          if (last) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      error_q    <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      vec_idx_q  <= '0;
      ff_idx_q   <= '0;
      ff_a_q     <= '0;
      ff_b_q     <= '0;
      ff_t_q     <= '0;
    end else begin
      state_q    <= state_d;
      error_q    <= error_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      vec_idx_q  <= vec_idx_d;
      ff_idx_q   <= ff_idx_d;
      ff_a_q     <= ff_a_d;
      ff_b_q     <= ff_b_d;
      ff_t_q     <= ff_t_d;
    end
  end

  assign vec_ready      = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN);
  assign done           = (state_q == S_DONE);
  assign error          = error_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign vec_idx        = vec_idx_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_a   = ff_a_q;
  assign first_fail_b   = ff_b_q;
  assign first_fail_t   = ff_t_q;

endmodule

// File: tb/tb_and_response_checker.sv
// Scoreboard bench for and_response_checker: a reference model predicts the state after each cycle.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_and_response_checker;

  logic       clk = 1'b0;
  logic       rst, start, start_s, vec_valid, last;
  logic [3:0] a, b, t;

  logic       vec_ready, busy, done, error;
  logic [7:0] pass_cnt, fail_cnt, vec_idx, first_fail_idx;
  logic [3:0] first_fail_a, first_fail_b, first_fail_t;

  logic       vec_ready_s, busy_s, done_s, error_s;
  logic [1:0] pass_cnt_s, fail_cnt_s, vec_idx_s, first_fail_idx_s;
  logic [3:0] first_fail_a_s, first_fail_b_s, first_fail_t_s;

  always #5 clk = ~clk;

  and_response_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .a(a), .b(b), .t(t), .last(last), .busy(busy), .done(done), .error(error),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .vec_idx(vec_idx),
    .first_fail_idx(first_fail_idx), .first_fail_a(first_fail_a),
    .first_fail_b(first_fail_b), .first_fail_t(first_fail_t)
  );

  and_response_checker #(.WIDTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .vec_valid(vec_valid), .vec_ready(vec_ready_s),
    .a(a), .b(b), .t(t), .last(last), .busy(busy_s), .done(done_s), .error(error_s),
    .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s), .vec_idx(vec_idx_s),
    .first_fail_idx(first_fail_idx_s), .first_fail_a(first_fail_a_s),
    .first_fail_b(first_fail_b_s), .first_fail_t(first_fail_t_s)
  );

  typedef struct {
    int pass; int fail; int idx; int err; int run; int dn;
    int ffi; int ffa; int ffb; int fft;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: 0 idle, 1 run, 2 done.
  int m_state, m_pass, m_fail, m_idx, m_err, m_ffi, m_ffa, m_ffb, m_fft;

  task automatic chk(input string tag, input int got, input int exp_v);
    n_chk++;
    if (got == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
  endtask

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_idx = 0; m_err = 0;
    m_ffi = 0; m_ffa = 0; m_ffb = 0; m_fft = 0;
  endtask

  task automatic model_vec(input int av, input int bv, input int tv, input int lv);
    if (m_state == 1) begin
      if (tv == (av & bv)) m_pass++;
      else begin
        if (m_fail == 0) begin
          m_ffi = m_idx; m_ffa = av; m_ffb = bv; m_fft = tv;
        end
        m_fail++;
        m_err = 1;
      end
      m_idx++;
      if (lv != 0) m_state = 2;
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    e.pass = m_pass; e.fail = m_fail; e.idx = m_idx; e.err = m_err;
    e.run = (m_state == 1) ? 1 : 0; e.dn = (m_state == 2) ? 1 : 0;
    e.ffi = m_ffi; e.ffa = m_ffa; e.ffb = m_ffb; e.fft = m_fft;
    return e;
  endfunction

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".pass_cnt"}, int'(pass_cnt), e.pass);
    chk({tag, ".fail_cnt"}, int'(fail_cnt), e.fail);
    chk({tag, ".vec_idx"}, int'(vec_idx), e.idx);
    chk({tag, ".error"}, int'(error), e.err);
    chk({tag, ".busy"}, int'(busy), e.run);
    chk({tag, ".vec_ready"}, int'(vec_ready), e.run);
    chk({tag, ".done"}, int'(done), e.dn);
    chk({tag, ".ff_idx"}, int'(first_fail_idx), e.ffi);
    chk({tag, ".ff_a"}, int'(first_fail_a), e.ffa);
    chk({tag, ".ff_b"}, int'(first_fail_b), e.ffb);
    chk({tag, ".ff_t"}, int'(first_fail_t), e.fft);
  endtask

  task automatic do_reset(input int cycles, input string tag);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    m_state = 0;
    model_clear();
    sb.push_back(snapshot());
    #1;
    rst = 1'b0;
    compare_front(tag);
  endtask

  // Start pulse, optionally with a vector offered in the same cycle.
  task automatic do_start(input bit with_vec, input string tag);
    @(negedge clk);
    start = 1'b1;
    vec_valid = with_vec;
    a = 4'b1111; b = 4'b1111; t = 4'b0000; last = 1'b0;
    if (with_vec && m_state == 1) model_vec(15, 15, 0, 0);
    if (m_state != 1) begin
      model_clear();
      m_state = 1;
    end
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    start = 1'b0; vec_valid = 1'b0;
    compare_front(tag);
  endtask

  task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] tv,
                      input bit lv, input string tag);
    @(negedge clk);
    a = av; b = bv; t = tv; last = lv; vec_valid = 1'b1;
    chk({tag, ".ready_pre"}, int'(vec_ready), (m_state == 1) ? 1 : 0);
    model_vec(int'(av), int'(bv), int'(tv), int'(lv));
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    vec_valid = 1'b0; last = 1'b0;
    compare_front(tag);
  endtask

  // Idle cycle; last is raised without vec_valid and must be ignored.
  task automatic bubble(input string tag);
    @(negedge clk);
    vec_valid = 1'b0; last = 1'b1;
    sb.push_back(snapshot());
    @(posedge clk);
    #1;
    last = 1'b0;
    compare_front(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_s = 1'b0; vec_valid = 1'b0; last = 1'b0;
    a = '0; b = '0; t = '0;
    m_state = 0;
    model_clear();

    do_reset(2, "reset");
    send(4'b0011, 4'b0001, 4'b0001, 1'b0, "idle_vec");

    do_start(1'b0, "golden.start");
    send(4'b0000, 4'b0000, 4'b0000, 1'b0, "golden.v0");
    send(4'b0001, 4'b0000, 4'b0000, 1'b0, "golden.v1");
    send(4'b0001, 4'b0001, 4'b0001, 1'b0, "golden.v2");
    send(4'b1011, 4'b1001, 4'b1001, 1'b1, "golden.v3");
    send(4'b0001, 4'b0001, 4'b0000, 1'b0, "done_vec");

    do_start(1'b0, "fault.start");
    send(4'b0000, 4'b0000, 4'b0000, 1'b0, "fault.v0");
    send(4'b0001, 4'b0000, 4'b0000, 1'b0, "fault.v1");
    send(4'b0001, 4'b0001, 4'b0000, 1'b0, "fault.v2");
    send(4'b1011, 4'b1001, 4'b1011, 1'b1, "fault.v3");
    chk("fault.ff_idx_abs", int'(first_fail_idx), 2);
    chk("fault.fail_abs", int'(fail_cnt), 2);

    do_start(1'b1, "rerun.start_with_vec");
    send(4'b1111, 4'b1010, 4'b1010, 1'b1, "rerun.v0");
    chk("rerun.pass_abs", int'(pass_cnt), 1);

    do_start(1'b0, "gaps.start");
    send(4'b0000, 4'b0000, 4'b0000, 1'b0, "gaps.v0");
    bubble("gaps.b0");
    send(4'b0001, 4'b0000, 4'b0000, 1'b0, "gaps.v1");
    do_start(1'b0, "gaps.midrun_start");
    bubble("gaps.b1");
    send(4'b0001, 4'b0001, 4'b0001, 1'b0, "gaps.v2");
    bubble("gaps.b2");
    send(4'b1011, 4'b1001, 4'b1001, 1'b1, "gaps.v3");
    chk("gaps.pass_abs", int'(pass_cnt), 4);

    do_start(1'b0, "midrst.start");
    send(4'b0110, 4'b0011, 4'b0000, 1'b0, "midrst.v0");
    send(4'b0110, 4'b0011, 4'b0010, 1'b0, "midrst.v1");
    do_reset(1, "midrst.reset");

    // Saturation: only the CNT_W=2 instance is started.
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    chk("sat.busy", int'(busy_s), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 4'(i + 3); b = 4'b0111; t = 4'(i + 3) & 4'b0111;
      vec_valid = 1'b1; last = (i == 4);
      @(posedge clk);
      #1;
      vec_valid = 1'b0; last = 1'b0;
    end
    chk("sat.pass_cnt", int'(pass_cnt_s), 3);
    chk("sat.vec_idx", int'(vec_idx_s), 3);
    chk("sat.fail_cnt", int'(fail_cnt_s), 0);
    chk("sat.done", int'(done_s), 1);
    chk("sat.error", int'(error_s), 0);
    chk("sat.main_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
